// File: rtl/program_sequencer_pkg.sv
// Shared types for the program sequencer: FSM state encoding and load-error codes.
package program_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_LOAD,
    ST_IDLE,
    ST_FETCH,
    ST_ISSUE,
    ST_HALT,
    ST_ERROR
  } state_t;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_OVERFLOW = 2'b01;
  localparam logic [1:0] ERR_PARTIAL  = 2'b10;
  localparam logic [1:0] ERR_EMPTY    = 2'b11;

endpackage

// File: rtl/program_sequencer_inst_mem.sv
// Instruction RAM: one row per instruction, per-slot byte-lane writes, registered read.
module program_sequencer_inst_mem
  import program_sequencer_pkg::*;
#(
  parameter int unsigned W        = 8,
  parameter int unsigned ARGS_PER = 4,
  parameter int unsigned DEPTH    = 256,
  parameter int unsigned PC_W     = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ARGS_PER-1:0]   i_we,
  input  logic [PC_W-1:0]       i_waddr,
  input  logic [W-1:0]          i_wdata,
  input  logic                  i_re,
  input  logic [PC_W-1:0]       i_raddr,
  output logic [ARGS_PER*W-1:0] o_rdata
);

  logic [ARGS_PER-1:0][W-1:0] r_mem [DEPTH];
  logic [ARGS_PER-1:0][W-1:0] r_rdata;

  always_ff @(posedge clock) begin
    for (int unsigned s = 0; s < ARGS_PER; s++) begin
      if (i_we[s]) r_mem[i_waddr][s] <= i_wdata;
    end
  end

  // Read register holds while i_re is low, keeping the issued instruction stable.
  always_ff @(posedge clock) begin
    if (reset)     r_rdata <= '0;
    else if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/program_sequencer.sv
// Loads a program byte stream into instruction RAM, then issues instructions
// one at a time with stall, jump, halt and restart support.
module program_sequencer
  import program_sequencer_pkg::*;
#(
  parameter int unsigned W        = 8,
  parameter int unsigned OP_W     = 8,
  parameter int unsigned ARGS_PER = 4,
  parameter int unsigned DEPTH    = 256,
  parameter int unsigned PC_W     = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       load_valid,
  input  logic [W-1:0]               load_data,
  input  logic                       load_done,
  output logic                       load_ready,
  input  logic                       run,
  input  logic                       stall,
  input  logic                       jump,
  input  logic [PC_W-1:0]            jump_target,
  output logic [OP_W-1:0]            i0,
  output logic [(ARGS_PER-1)*W-1:0]  args,
  output logic                       inst_valid,
  output logic [PC_W-1:0]            pc,
  output logic [PC_W:0]              no_instructions,
  output logic                       halted,
  output logic [1:0]                 error
);

  localparam int unsigned   SW        = $clog2(ARGS_PER);
  localparam logic [SW-1:0] LAST_SLOT = SW'(ARGS_PER - 1);
  localparam logic [PC_W:0] FULL      = (PC_W + 1)'(DEPTH);

  state_t              r_state, w_state_nxt;
  logic [PC_W:0]       r_count, w_count_nxt;
  logic [SW-1:0]       r_slot, w_slot_nxt;
  logic [PC_W-1:0]     r_pc, w_pc_nxt;
  logic [PC_W:0]       r_no_instr, w_no_instr_nxt;
  logic                r_halted, w_halted_nxt;
  logic [1:0]          r_error, w_error_nxt;
  logic                w_wr, w_re;
  logic [PC_W:0]       w_next_pc;
  logic [ARGS_PER-1:0] w_we;
  logic [ARGS_PER*W-1:0] w_rdata;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= ST_LOAD;
      r_count    <= '0;
      r_slot     <= '0;
      r_pc       <= '0;
      r_no_instr <= '0;
      r_halted   <= 1'b0;
      r_error    <= ERR_NONE;
    end else begin
      r_state    <= w_state_nxt;
      r_count    <= w_count_nxt;
      r_slot     <= w_slot_nxt;
      r_pc       <= w_pc_nxt;
      r_no_instr <= w_no_instr_nxt;
      r_halted   <= w_halted_nxt;
      r_error    <= w_error_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_count_nxt    = r_count;
    w_slot_nxt     = r_slot;
    w_pc_nxt       = r_pc;
    w_no_instr_nxt = r_no_instr;
    w_halted_nxt   = r_halted;
    w_error_nxt    = r_error;
    w_wr           = 1'b0;
    w_re           = 1'b0;
    w_next_pc      = jump ? {1'b0, jump_target} : {1'b0, r_pc} + 1'b1;
    case (r_state)
      ST_LOAD: begin
        if (load_valid) begin
          if (r_count == FULL) begin
            w_state_nxt = ST_ERROR;
            w_error_nxt = ERR_OVERFLOW;
          end else begin
            w_wr = 1'b1;
            if (r_slot == LAST_SLOT) begin
              w_slot_nxt  = '0;
              w_count_nxt = r_count + 1'b1;
            end else begin
              w_slot_nxt  = r_slot + 1'b1;
            end
          end
        end
        // End-of-stream checks see the counters after any same-cycle word.
        if (load_done && (w_state_nxt == ST_LOAD)) begin
          if (w_count_nxt == '0) begin
            w_state_nxt = ST_ERROR;
            w_error_nxt = ERR_EMPTY;
          end else if (w_slot_nxt != '0) begin
            w_state_nxt = ST_ERROR;
            w_error_nxt = ERR_PARTIAL;
          end else begin
            w_state_nxt    = ST_IDLE;
            w_no_instr_nxt = w_count_nxt;
          end
        end
      end
      ST_IDLE, ST_HALT: begin
        if (run) begin
          w_state_nxt  = ST_FETCH;
          w_pc_nxt     = '0;
          w_halted_nxt = 1'b0;
        end
      end
      ST_FETCH: begin
        w_re        = 1'b1;
        w_state_nxt = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (!stall) begin
          if (w_next_pc >= r_no_instr) begin
            w_state_nxt  = ST_HALT;
            w_halted_nxt = 1'b1;
          end else begin
            w_pc_nxt    = w_next_pc[PC_W-1:0];
            w_state_nxt = ST_FETCH;
          end
        end
      end
      default: ;
    endcase
  end

  assign w_we = w_wr ? ({{(ARGS_PER-1){1'b0}}, 1'b1} << r_slot) : '0;

  program_sequencer_inst_mem #(
    .W        (W),
    .ARGS_PER (ARGS_PER),
    .DEPTH    (DEPTH),
    .PC_W     (PC_W)
  ) u_mem (
    .clock   (clock),
    .reset   (reset),
    .i_we    (w_we),
    .i_waddr (r_count[PC_W-1:0]),
    .i_wdata (load_data),
    .i_re    (w_re),
    .i_raddr (r_pc),
    .o_rdata (w_rdata)
  );

  assign load_ready      = (r_state == ST_LOAD);
  assign inst_valid      = (r_state == ST_ISSUE);
  assign i0              = w_rdata[OP_W-1:0];
  assign args            = w_rdata[ARGS_PER*W-1:W];
  assign pc              = r_pc;
  assign no_instructions = r_no_instr;
  assign halted          = r_halted;
  assign error           = r_error;

endmodule

// File: tb/tb_program_sequencer.sv
// Scoreboard bench for program_sequencer: a program-level model predicts the
// issued instruction sequence; a monitor compares every issue cycle.
module tb_program_sequencer;

  localparam int W = 8, OP_W = 8, AP = 4, DEPTH = 256, PC_W = 8;

  logic clock = 1'b0;
  logic reset = 1'b1, load_valid = 1'b0, load_done = 1'b0;
  logic run = 1'b0, stall = 1'b0, jump = 1'b0;
  logic [W-1:0] load_data = '0;
  logic [PC_W-1:0] jump_target = '0;
  logic load_ready, inst_valid, halted;
  logic [OP_W-1:0] i0;
  logic [(AP-1)*W-1:0] args;
  logic [PC_W-1:0] pc;
  logic [PC_W:0] no_instructions;
  logic [1:0] error;

  program_sequencer #(.W(W), .OP_W(OP_W), .ARGS_PER(AP), .DEPTH(DEPTH), .PC_W(PC_W)) dut (
    .clock(clock), .reset(reset), .load_valid(load_valid), .load_data(load_data),
    .load_done(load_done), .load_ready(load_ready), .run(run), .stall(stall),
    .jump(jump), .jump_target(jump_target), .i0(i0), .args(args),
    .inst_valid(inst_valid), .pc(pc), .no_instructions(no_instructions),
    .halted(halted), .error(error)
  );

  always #5 clock = ~clock;

  typedef struct { int pc; logic [7:0] i0; logic [23:0] args; } exp_t;
  exp_t exp_q[$];
  int checks = 0, failures = 0, accepts = 0;
  logic [7:0]  prog_i0[$];
  logic [23:0] prog_args[$];
  logic [W-1:0] load_q[$];
  bit plan_jmp[$];
  int plan_tgt[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: every issue cycle must show the head of the expected queue; pop on acceptance.
  initial begin
    forever begin
      @(negedge clock); #1;
      if (inst_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_issue actual pc=%0d required=no issue", pc);
        end else begin
          chk("issue_pc", 64'(pc), 64'(exp_q[0].pc));
          chk("issue_i0", 64'(i0), 64'(exp_q[0].i0));
          chk("issue_args", 64'(args), 64'(exp_q[0].args));
          if (!stall && !reset) begin
            void'(exp_q.pop_front());
            accepts++;
          end
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  task automatic add_instr(input logic [7:0] op, input logic [23:0] a);
    prog_i0.push_back(op);
    prog_args.push_back(a);
    load_q.push_back(op);
    load_q.push_back(a[7:0]);
    load_q.push_back(a[15:8]);
    load_q.push_back(a[23:16]);
  endtask

  task automatic clear_prog;
    prog_i0.delete(); prog_args.delete(); load_q.delete();
  endtask

  task automatic make_random_prog(input int n);
    clear_prog();
    for (int j = 0; j < n; j++) add_instr(8'($urandom), 24'($urandom));
  endtask

  task automatic do_reset;
    reset = 1'b1; stall = 1'b0; jump = 1'b0; run = 1'b0; load_valid = 1'b0; load_done = 1'b0;
    @(negedge clock); @(negedge clock);
    reset = 1'b0;
    exp_q.delete();
    chk("reset_load_ready", 64'(load_ready), 64'd1);
    chk("reset_inst_valid", 64'(inst_valid), 64'd0);
    chk("reset_pc", 64'(pc), 64'd0);
    chk("reset_halted", 64'(halted), 64'd0);
    chk("reset_error", 64'(error), 64'd0);
    chk("reset_no_instr", 64'(no_instructions), 64'd0);
  endtask

  task automatic load_stream(input bit gaps, input bit done_last);
    for (int i = 0; i < load_q.size(); i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          load_valid = 1'b0; @(negedge clock);
        end
      end
      load_valid = 1'b1;
      load_data  = load_q[i];
      load_done  = done_last && (i == load_q.size() - 1);
      @(negedge clock);
    end
    load_valid = 1'b0;
    if (!(done_last && load_q.size() > 0)) begin
      load_done = 1'b1; @(negedge clock);
    end
    load_done = 1'b0;
  endtask

  task automatic expect_load(input int nw);
    int n = nw / AP;
    int e = (n == 0) ? 3 : ((nw % AP) != 0) ? 2 : 0;
    chk("load_error", 64'(error), 64'(e));
    chk("load_ready_after_done", 64'(load_ready), 64'd0);
    chk("load_no_instr", 64'(no_instructions), 64'((e == 0) ? n : 0));
  endtask

  // Program-level reference: walk pc through the program applying the jump plan.
  task automatic build_expected(output int nexp);
    int p = 0, k = 0, nxt, n;
    exp_t e;
    n = prog_i0.size();
    nexp = 0;
    while (1) begin
      e.pc = p; e.i0 = prog_i0[p]; e.args = prog_args[p];
      exp_q.push_back(e);
      nexp++;
      nxt = (k < plan_jmp.size() && plan_jmp[k]) ? plan_tgt[k] : p + 1;
      k++;
      if (nxt >= n) break;
      p = nxt;
    end
  endtask

  task automatic run_prog(input int first_stall, input int stall_pct, input int abort_pc);
    int nexp, acc0, k = 0, stall_left = first_stall, cyc = 0;
    bit aborted = 0;
    build_expected(nexp);
    acc0 = accepts;
    run = 1'b1; @(negedge clock); run = 1'b0;
    chk("latency_fetch_valid", 64'(inst_valid), 64'd0);
    chk("run_clears_halted", 64'(halted), 64'd0);
    @(negedge clock);
    chk("latency_issue_valid", 64'(inst_valid), 64'd1);
    while (halted !== 1'b1 && cyc < 2000) begin
      run = ($urandom_range(0, 7) == 0);
      if (inst_valid === 1'b1) begin
        if (abort_pc >= 0 && int'(pc) == abort_pc) begin
          stall = 1'b1; reset = 1'b1; run = 1'b0; aborted = 1;
          break;
        end
        if (stall_left > 0 || $urandom_range(0, 99) < stall_pct) begin
          if (stall_left > 0) stall_left--;
          stall = 1'b1; jump = 1'($urandom); jump_target = PC_W'($urandom);
        end else begin
          stall = 1'b0;
          jump = (k < plan_jmp.size()) ? plan_jmp[k] : 1'b0;
          jump_target = (k < plan_tgt.size()) ? PC_W'(plan_tgt[k]) : PC_W'($urandom);
          k++;
        end
      end else begin
        stall = 1'($urandom); jump = 1'($urandom); jump_target = PC_W'($urandom);
      end
      @(negedge clock);
      cyc++;
    end
    run = 1'b0;
    if (aborted) begin
      @(negedge clock);
      reset = 1'b0; stall = 1'b0; jump = 1'b0;
      chk("abort_load_ready", 64'(load_ready), 64'd1);
      chk("abort_inst_valid", 64'(inst_valid), 64'd0);
      chk("abort_pc", 64'(pc), 64'd0);
      chk("abort_halted", 64'(halted), 64'd0);
      exp_q.delete();
      return;
    end
    chk("halted", 64'(halted), 64'd1);
    chk("halt_error", 64'(error), 64'd0);
    chk("halt_inst_valid", 64'(inst_valid), 64'd0);
    chk("accept_count", 64'(accepts - acc0), 64'(nexp));
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    stall = 1'b0; jump = 1'b0;
  endtask

  task automatic check_sticky(input logic [1:0] e);
    for (int i = 0; i < 4; i++) begin
      run = 1'b1; load_valid = 1'($urandom); load_data = W'($urandom); load_done = 1'($urandom);
      @(negedge clock);
      chk("sticky_error", 64'(error), 64'(e));
      chk("sticky_inst_valid", 64'(inst_valid), 64'd0);
      chk("sticky_load_ready", 64'(load_ready), 64'd0);
    end
    run = 1'b0; load_valid = 1'b0; load_done = 1'b0;
  endtask

  initial begin
    int n;
    do_reset();

    clear_prog();
    add_instr(8'h01, 24'h0C0B0A);
    add_instr(8'h02, 24'h1C1B1A);
    load_stream(0, 0);
    expect_load(8);
    plan_jmp.delete(); plan_tgt.delete();
    run_prog(0, 0, -1);
    run_prog(5, 0, -1);

    do_reset();
    make_random_prog(4);
    load_stream(1, 1);
    expect_load(16);
    plan_jmp = '{1'b1}; plan_tgt = '{3};
    run_prog(0, 0, -1);
    plan_tgt = '{7};
    run_prog(0, 0, -1);

    repeat (8) begin
      do_reset();
      n = $urandom_range(1, 10);
      make_random_prog(n);
      load_stream(1, 1'($urandom));
      expect_load(n * AP);
      repeat (2) begin
        plan_jmp.delete(); plan_tgt.delete();
        repeat ($urandom_range(0, 5)) begin
          plan_jmp.push_back($urandom_range(0, 99) < 40);
          plan_tgt.push_back($urandom_range(0, n + 2));
        end
        run_prog($urandom_range(0, 3), 30, -1);
      end
    end

    do_reset();
    make_random_prog(3);
    load_stream(0, 1);
    expect_load(12);
    plan_jmp.delete(); plan_tgt.delete();
    run_prog(0, 0, 1);
    load_stream(1, 0);
    expect_load(12);
    run_prog(0, 20, -1);

    do_reset();
    clear_prog();
    for (int i = 0; i < 6; i++) load_q.push_back(W'($urandom));
    load_stream(0, 1);
    expect_load(6);
    check_sticky(2'b10);

    do_reset();
    clear_prog();
    load_stream(0, 0);
    expect_load(0);
    check_sticky(2'b11);

    do_reset();
    for (int i = 0; i < DEPTH * AP + 1; i++) begin
      if (i == DEPTH * AP) begin
        chk("pre_overflow_error", 64'(error), 64'd0);
        chk("pre_overflow_ready", 64'(load_ready), 64'd1);
      end
      load_valid = 1'b1; load_data = W'(i);
      @(negedge clock);
    end
    load_valid = 1'b0;
    chk("overflow_error", 64'(error), 64'd1);
    chk("overflow_ready", 64'(load_ready), 64'd0);
    check_sticky(2'b01);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/program_sequencer.md
Name: program_sequencer

Overview:
- Hardware replacement for the file-driven instruction stepping loop at the top level.
- Accepts a program as a byte stream into on-chip instruction memory, then issues instructions one at a time to the decoder (op plus argument words) with a valid/stall handshake.
- Adds what the fixed loop lacks: parametrised instruction geometry and depth, jumps, stall, halt, restart, and load-error reporting.

Parameters:
- W, 8, argument word / load byte width
- OP_W, 8, opcode width; must be <= W; low OP_W bits of slot 0 are used
- ARGS_PER, 4, words per instruction including the opcode slot; must be >= 2
- DEPTH, 256, maximum number of instructions
- PC_W, 8, program counter width; 2**PC_W >= DEPTH

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- load_valid  in  1  one load_data word presented this cycle
- load_data  in  W  program word, instruction-major, opcode slot first
- load_done  in  1  end of program stream
- load_ready  out  1  high while in LOAD
- run  in  1  start/restart execution from pc 0
- stall  in  1  hold the current instruction
- jump  in  1  take jump_target as next pc; sampled with an accepted instruction
- jump_target  in  PC_W  jump destination
- i0  out  OP_W  opcode of the issued instruction
- args  out  (ARGS_PER-1)*W  arguments; slot 1 in the LSBs
- inst_valid  out  1  i0/args valid this cycle
- pc  out  PC_W  index of the issued instruction
- no_instructions  out  PC_W+1  instructions loaded
- halted  out  1  program ran off the end
- error  out  2  00 none, 01 overflow, 10 partial instruction, 11 empty program

Behaviour:
- States: LOAD, IDLE, FETCH, ISSUE, HALT, ERROR.
- Reset (any state, including mid-run): state LOAD; pc, counters and all outputs 0. Memory contents are not cleared.
- LOAD:
  - On load_valid, write load_data to mem[count][slot].
  - Slot wraps ARGS_PER-1 -> 0, and count increments on that wrap.
  - load_valid while count == DEPTH -> ERROR, error=01; the word is dropped.
- load_done in LOAD:
  - A same-cycle load_valid word is written first; the checks then use the updated count and slot.
  - count==0 -> ERROR, error=11.
  - slot!=0 -> ERROR, error=10.
  - Otherwise -> IDLE, and no_instructions=count.
- IDLE / HALT: run -> FETCH with pc=0. HALT holds halted=1; halted clears on run.
- FETCH:
  - Synchronous memory read of mem[pc].
  - Next state is ISSUE.
- ISSUE:
  - inst_valid=1.
  - i0, args and pc hold stable while stall=1.
  - Acceptance occurs on a cycle with stall=0.
  - On acceptance: next = jump ? jump_target : pc+1.
  - If next >= no_instructions -> HALT, with inst_valid low the following cycle.
  - Otherwise pc=next and the state returns to FETCH.
  - jump is ignored when stall=1.
- Timing:
  - Latency: run high in IDLE -> inst_valid at the second rising edge after.
  - Throughput: one instruction per 2 cycles, matching the tick/tock decode phase.
- ERROR is sticky until reset; inst_valid=0 and load_ready=0 there.
- Outside ISSUE, inst_valid=0; i0/args keep their last value and are not checked.
- run asserted in LOAD, FETCH or ISSUE is ignored.

Decomposition:
- Shared package:
  - state enum (LOAD..ERROR)
  - error code constants ERR_NONE, ERR_OVERFLOW, ERR_PARTIAL, ERR_EMPTY
- One sub-module, inst_mem: DEPTH x (ARGS_PER*W) RAM with per-slot write enable and a registered read port.
- Loader counters, pc and FSM live in program_sequencer.

Test Plan:
- Load 8 words (2 instructions: 01 0A 0B 0C, 02 1A 1B 1C), load_done, run with stall=0.
  - Required: no_instructions=2.
  - Issue 1: inst_valid pulses with pc=0, i0=01, args=0C0B0A.
  - Issue 2: pc=1, i0=02, args=1C1B1A.
  - Then halted=1, error=00.
- Same program, stall=1 for 5 cycles during the first issue.
  - Required: i0=01 and pc=0 held for all 5 cycles; exactly 2 acceptances total.
- 4-instruction program, jump=1 with jump_target=3 on acceptance of pc=0.
  - Required: next issued pc=3, then halt.
  - Repeat with jump_target=7 -> HALT directly.
- Load errors:
  - 6 words then load_done -> error=10.
  - load_done with no words -> error=11.
  - DEPTH*ARGS_PER+1 words -> error=01 on the last word.
  - In all three: state sticky, inst_valid stays 0.
- Reset asserted during ISSUE of pc=1.
  - Required: next cycle load_ready=1, inst_valid=0, pc=0, halted=0.
- After HALT, assert run again.
  - Required: program re-executes from pc=0 without reload, same i0/args sequence.
